// File: rtl/stopwatch_lap_bcd.sv
// Stopwatch core: clock divider, native BCD timer, start/stop/clear FSM and lap-freeze display.
// Optional lap capture is built only when STOPWATCH_LAP_CAPTURE_EN is defined.
module stopwatch_lap_bcd #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned DIGITS   = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start_btn,
  input  logic                  stop_btn,
  input  logic                  lap_btn,
  input  logic                  clear_btn,
  output logic                  tick,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_live,
  output logic [4*DIGITS-1:0]   bcd_disp
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nx;

  // button bits: [2] clear, [1] stop, [0] start
  logic [2:0] sync1, sync2, prev, edge_q;
  logic       clr_ev, stp_ev, sta_ev;
  logic [DW-1:0] div_cnt;
  logic [4*DIGITS-1:0] bcd_inc;
  logic       carry;
  logic       all_nines;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= {clear_btn, stop_btn, start_btn};
      sync2  <= sync1;
      prev   <= sync2;
      edge_q <= sync2 & ~prev;
    end
  end

  // Same-cycle priority clear > stop > start; losers are dropped.
  assign clr_ev = edge_q[2];
  assign stp_ev = edge_q[1] & ~edge_q[2];
  assign sta_ev = edge_q[0] & ~(|edge_q[2:1]);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_ev)                          state_nx = IDLE;
    else if (stp_ev && state == RUN)     state_nx = PAUSE;
    else if (sta_ev && state != RUN)     state_nx = RUN;
  end

  assign running = (state == RUN);
  assign tick    = running && (div_cnt == DIV_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)     div_cnt <= '0;
    else if (clr_ev)  div_cnt <= '0;
    else if (running) div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Ripple increment; carry survives the loop only when every digit was 9.
  always_comb begin
    bcd_inc = bcd_live;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_live[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_live[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bcd_live <= '0;
      overflow <= 1'b0;
    end else if (clr_ev) begin
      bcd_live <= '0;
      overflow <= 1'b0;
    end else if (tick) begin
      if (!(all_nines && SATURATE)) bcd_live <= bcd_inc;
      if (all_nines) overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic lap_s1, lap_s2, lap_prev, lap_edge, lap_ev;
  logic [4*DIGITS-1:0] lap_reg;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      lap_s1   <= 1'b0;
      lap_s2   <= 1'b0;
      lap_prev <= 1'b0;
      lap_edge <= 1'b0;
    end else begin
      lap_s1   <= lap_btn;
      lap_s2   <= lap_s1;
      lap_prev <= lap_s2;
      lap_edge <= lap_s2 & ~lap_prev;
    end
  end

  assign lap_ev = lap_edge & ~(|edge_q);

  // Snapshot takes the pre-increment value of bcd_live.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else if (clr_ev) begin
      lap_active <= 1'b0;
    end else if (lap_ev) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else if (running) begin
        lap_active <= 1'b1;
        lap_reg    <= bcd_live;
      end
    end
  end

  assign bcd_disp = lap_active ? lap_reg : bcd_live;
`else
  logic unused_lap;
  assign unused_lap = lap_btn;
  assign lap_active = 1'b0;
  assign bcd_disp   = bcd_live;
`endif

endmodule

// File: tb/tb_stopwatch_lap_bcd.sv
// Bench for stopwatch_lap_bcd: tick-count model plus directed literal checks.
// Three instances share stimulus: 8-digit wrap, 2-digit wrap, 2-digit saturate.
module tb_stopwatch_lap_bcd;
  localparam int DIV = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic start_btn = 1'b0, stop_btn = 1'b0, lap_btn = 1'b0, clear_btn = 1'b0;

  logic        tk8, rn8, la8, ov8;
  logic [31:0] lv8, dp8;
  logic        tkA, rnA, laA, ovA;
  logic [7:0]  lvA, dpA;
  logic        tkB, rnB, laB, ovB;
  logic [7:0]  lvB, dpB;

  int n_checks = 0;
  int n_err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  stopwatch_lap_bcd #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(8), .SATURATE(1'b0)) u_w8 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start_btn(start_btn), .stop_btn(stop_btn),
    .lap_btn(lap_btn), .clear_btn(clear_btn), .tick(tk8), .running(rn8),
    .lap_active(la8), .overflow(ov8), .bcd_live(lv8), .bcd_disp(dp8));

  stopwatch_lap_bcd #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .SATURATE(1'b0)) u_s0 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start_btn(start_btn), .stop_btn(stop_btn),
    .lap_btn(lap_btn), .clear_btn(clear_btn), .tick(tkA), .running(rnA),
    .lap_active(laA), .overflow(ovA), .bcd_live(lvA), .bcd_disp(dpA));

  stopwatch_lap_bcd #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .SATURATE(1'b1)) u_s1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start_btn(start_btn), .stop_btn(stop_btn),
    .lap_btn(lap_btn), .clear_btn(clear_btn), .tick(tkB), .running(rnB),
    .lap_active(laB), .overflow(ovB), .bcd_live(lvB), .bcd_disp(dpB));

  logic [67:0] act8, actA, actB;
  assign act8 = {tk8, rn8, la8, ov8, lv8, dp8};
  assign actA = {tkA, rnA, laA, ovA, 24'h0, lvA, 24'h0, dpA};
  assign actB = {tkB, rnB, laB, ovB, 24'h0, lvB, 24'h0, dpB};

  // ---------------- model: state, divider phase, ticks since clear ----------------
  int      m_st = M_IDLE;
  int      m_phase = 0;
  longint  m_cnt = 0;
  longint  m_snap = 0;
  bit      m_lap = 1'b0;
  bit [3:0] hs = '0, hp = '0, hl = '0, hc = '0;

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_st = M_IDLE; m_phase = 0; m_cnt = 0; m_snap = 0; m_lap = 1'b0;
      hs = '0; hp = '0; hl = '0; hc = '0;
    end else begin
      bit ec, ep, es, el, tk;
      ec = hc[2] & ~hc[3];
      ep = hp[2] & ~hp[3];
      es = hs[2] & ~hs[3];
      el = hl[2] & ~hl[3];
      if (ec) begin ep = 0; es = 0; el = 0; end
      if (ep) begin es = 0; el = 0; end
      if (es) el = 0;
      tk = (m_st == M_RUN) && (m_phase == DIV - 1);
      if (ec) begin
        m_st = M_IDLE; m_phase = 0; m_cnt = 0; m_lap = 1'b0;
      end else begin
        if (el) begin
          if (m_lap) m_lap = 1'b0;
          else if (m_st == M_RUN) begin m_lap = 1'b1; m_snap = m_cnt; end
        end
        if (m_st == M_RUN) begin
          if (tk) begin m_cnt++; m_phase = 0; end
          else m_phase++;
        end
        if (ep && m_st == M_RUN) m_st = M_PAUSE;
        else if (es && m_st != M_RUN) m_st = M_RUN;
      end
      hs = {hs[2:0], start_btn};
      hp = {hp[2:0], stop_btn};
      hl = {hl[2:0], lap_btn};
      hc = {hc[2:0], clear_btn};
    end
  end

  function automatic logic [31:0] to_bcd(longint v);
    logic [31:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint sat99(longint v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic check(string name, logic [67:0] act, logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge CLOCK_50) begin
    bit tk, rn, lp;
    logic [31:0] l8, d8, lA, dA, lB, dB;
    tk = (m_st == M_RUN) && (m_phase == DIV - 1);
    rn = (m_st == M_RUN);
`ifdef STOPWATCH_LAP_CAPTURE_EN
    lp = m_lap;
`else
    lp = 1'b0;
`endif
    l8 = to_bcd(m_cnt % 100000000);
    d8 = lp ? to_bcd(m_snap % 100000000) : l8;
    lA = to_bcd(m_cnt % 100);
    dA = lp ? to_bcd(m_snap % 100) : lA;
    lB = to_bcd(sat99(m_cnt));
    dB = lp ? to_bcd(sat99(m_snap)) : lB;
    check("model dut8", act8, {tk, rn, lp, m_cnt >= 100000000, l8, d8});
    check("model dut2wrap", actA, {tk, rn, lp, m_cnt >= 100, lA, dA});
    check("model dut2sat", actB, {tk, rn, lp, m_cnt >= 100, lB, dB});
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press_start(); start_btn = 1; cycles(1); start_btn = 0; endtask
  task automatic press_stop();  stop_btn  = 1; cycles(1); stop_btn  = 0; endtask
  task automatic press_lap();   lap_btn   = 1; cycles(1); lap_btn   = 0; endtask
  task automatic press_clear(); clear_btn = 1; cycles(1); clear_btn = 0; endtask

  task automatic wait_count(longint target, int budget);
    int n;
    n = 0;
    while (m_cnt != target && n < budget) begin
      cycles(1);
      n++;
    end
    n_checks++;
    if (m_cnt != target) begin
      n_err++;
      $display("FAIL wait_count: model count %0d want %0d after %0d cycles", m_cnt, target, n);
    end
  endtask

  initial begin
    int ticks;
    int n;
    cycles(3);
    check("reset dut8", act8, '0);
    check("reset dut2", actB, '0);
    RESET_N = 1;
    cycles(2);

    // start from IDLE, 25 ticks in 25*DIV cycles
    press_start();
    n = 0;
    while (!rn8 && n < 10) begin cycles(1); n++; end
    check("t2 running rose", 68'(rn8), 68'd1);
    ticks = 0;
    for (int i = 0; i < 25 * DIV; i++) begin
      cycles(1);
      if (tk8) ticks++;
    end
    check("t2 live", 68'(lv8), 68'h25);
    check("t2 tick count", 68'(ticks), 68'd25);
    check("t2 live 2digit", 68'(lvA), 68'h25);

    // stop at 7, hold while paused, resume to 10
    press_clear();
    cycles(5);
    check("clear live", 68'(lv8), 68'h0);
    press_start();
    wait_count(7, 200);
    press_stop();
    cycles(10);
    check("t3 paused running", 68'(rn8), 68'd0);
    check("t3 paused live", 68'(lv8), 68'h7);
    cycles(50);
    check("t3 held live", 68'(lv8), 68'h7);
    press_stop();
    cycles(5);
    press_start();
    wait_count(10, 200);
    check("t3 resumed live", 68'(lv8), 68'h10);

    // lap at 12, run to 20, lap again
    wait_count(12, 200);
    press_lap();
    cycles(5);
    wait_count(20, 200);
    cycles(1);
    check("t4 live", 68'(lv8), 68'h20);
`ifdef STOPWATCH_LAP_CAPTURE_EN
    check("t4 disp frozen", 68'(dp8), 68'h12);
    check("t4 lap_active", 68'(la8), 68'd1);
`else
    check("t4 disp follows", 68'(dp8), 68'h20);
    check("t4 lap_active", 68'(la8), 68'd0);
`endif
    press_lap();
    cycles(5);
    check("t4 disp after unlap", 68'(dp8), 68'h20);
    check("t4 lap_active off", 68'(la8), 68'd0);

    // clear and start together at 40
    wait_count(40, 300);
    clear_btn = 1; start_btn = 1;
    cycles(1);
    clear_btn = 0; start_btn = 0;
    cycles(5);
    check("t6 running", 68'(rn8), 68'd0);
    check("t6 live", 68'(lv8), 68'h0);
    check("t6 overflow", 68'(ov8), 68'd0);
    press_lap();
    cycles(5);
    check("lap in idle ignored", 68'(la8), 68'd0);

    // 2-digit overflow: wrap vs saturate
    press_start();
    wait_count(99, 1100);
    wait_count(100, 20);
    check("t5 wrap live", 68'(lvA), 68'h00);
    check("t5 wrap overflow", 68'(ovA), 68'd1);
    check("t5 sat live", 68'(lvB), 68'h99);
    check("t5 sat overflow", 68'(ovB), 68'd1);
    check("t5 dut8 live", 68'(lv8), 68'h100);
    cycles(25);
    check("t5 sat held", 68'(lvB), 68'h99);
    check("t5 sat running", 68'(rnB), 68'd1);

    // asynchronous reset mid-run with buttons active
    start_btn = 1; stop_btn = 1; lap_btn = 1;
    #2 RESET_N = 0;
    #1;
    check("t1 async reset dut8", act8, '0);
    check("t1 async reset sat", actB, '0);
    cycles(1);
    start_btn = 0; stop_btn = 0; lap_btn = 0;
    cycles(2);
    RESET_N = 1;
    cycles(10);
    check("t1 idle after reset", 68'(rn8), 68'd0);
    check("t1 live after reset", 68'(lv8), 68'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
